// File: rtl/seq_checker.sv
// seq_checker: locks onto the 1,2,3,5,7,11,13 counter sequence and flags violations once locked
module seq_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [3:0]       q_in,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err,
  output logic [3:0]       expected,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] lap_count
);
  typedef enum logic [1:0] {HUNT = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2} state_t;
  state_t state, state_n;
  logic [3:0] exp_n;
  logic err_n, lap_inc;
  function automatic logic [3:0] succ(input logic [3:0] v);
    case (v)
      4'd1:    succ = 4'd2;
      4'd2:    succ = 4'd3;
      4'd3:    succ = 4'd5;
      4'd5:    succ = 4'd7;
      4'd7:    succ = 4'd11;
      4'd11:   succ = 4'd13;
      4'd13:   succ = 4'd1;
      default: succ = 4'd0;
    endcase
  endfunction
  // a value is legal exactly when it has a successor
  function automatic logic legal(input logic [3:0] v);
    legal = succ(v) != 4'd0;
  endfunction
  always_comb begin
    state_n = state;
    exp_n   = expected;
    err_n   = 1'b0;
    lap_inc = 1'b0;
    case (state)
      HUNT: if (en) begin
        state_n = legal(q_in) ? CONFIRM : HUNT;
        exp_n   = succ(q_in);
      end
      CONFIRM: if (en) begin
        state_n = (q_in == expected) ? LOCKED : legal(q_in) ? CONFIRM : HUNT;
        exp_n   = succ(q_in);
      end
      LOCKED: if (en) begin
        state_n = (q_in == expected) ? LOCKED : HUNT;
        exp_n   = (q_in == expected) ? succ(q_in) : 4'd0;
        err_n   = q_in != expected;
        lap_inc = (q_in == expected) && (q_in == 4'd1);
      end
      default: begin
        state_n = HUNT;
        exp_n   = 4'd0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= HUNT;
      expected  <= 4'd0;
      err       <= 1'b0;
      err_count <= '0;
      lap_count <= '0;
    end else begin
      state     <= state_n;
      expected  <= exp_n;
      err       <= err_n;
      err_count <= cnt_clr ? '0 : (err_n && ~&err_count) ? err_count + CNT_W'(1) : err_count;
      lap_count <= cnt_clr ? '0 : lap_inc ? lap_count + CNT_W'(1) : lap_count;
    end
  end
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed and random stimulus against a run-length reference model of seq_checker
module tb_seq_checker;
  logic clk = 1'b0, clear_n = 1'b0, en = 1'b0, cnt_clr = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic locked, err;
  logic [3:0] expected;
  logic [7:0] err_count, lap_count;
  int n_cmp = 0, n_bad = 0;
  int m_exp = 0, m_run = 0, m_err = 0, m_ec = 0, m_lc = 0;
  int seq_v[7] = '{1, 2, 3, 5, 7, 11, 13};

  always #5 clk = ~clk;

  seq_checker #(.CNT_W(8)) dut (
    .clk(clk), .clear_n(clear_n), .en(en), .q_in(q_in), .cnt_clr(cnt_clr),
    .locked(locked), .err(err), .expected(expected),
    .err_count(err_count), .lap_count(lap_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int nxt(input int v);
    for (int i = 0; i < 7; i++) if (seq_v[i] == v) return seq_v[(i + 1) % 7];
    return 0;
  endfunction

  task automatic model_reset();
    m_exp = 0; m_run = 0; m_err = 0; m_ec = 0; m_lc = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"}, 32'(locked), 32'(m_run >= 2));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".expected"}, 32'(expected), 32'(m_exp));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_ec));
    chk({tag, ".lap_count"}, 32'(lap_count), 32'(m_lc));
  endtask

  // m_run counts consecutive on-sequence samples since the last hunt (capped at 2 = locked)
  task automatic step(input bit e, input int q, input bit c, input string tag);
    en = e; q_in = 4'(q); cnt_clr = c;
    @(posedge clk);
    m_err = 0;
    if (e) begin
      if (m_run >= 2) begin
        if (q == m_exp) begin
          if (q == 1) m_lc = (m_lc + 1) % 256;
          m_exp = nxt(q);
        end else begin
          m_err = 1;
          if (m_ec < 255) m_ec++;
          m_run = 0;
          m_exp = 0;
        end
      end else if (m_run == 1 && q == m_exp) begin
        m_run = 2; m_exp = nxt(q);
      end else if (nxt(q) != 0) begin
        m_run = 1; m_exp = nxt(q);
      end else begin
        m_run = 0; m_exp = 0;
      end
    end
    if (c) begin m_ec = 0; m_lc = 0; end
    #1 check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 clear_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(posedge clk);
    #1 check_all({tag, ".held"});
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  initial begin
    int e, q, c;
    #1 check_all("reset");
    @(negedge clk);
    clear_n = 1'b1;
    step(1, 1, 0, "lock1");
    step(1, 2, 0, "lock2");
    step(1, 3, 0, "lock3");
    chk("lock3.expected5", 32'(expected), 32'd5);
    foreach (seq_v[i]) if (i >= 3) step(1, seq_v[i], 0, "lap");
    step(1, 1, 0, "lap.wrap");
    step(1, 2, 0, "lap.2");
    chk("lap.count1", 32'(lap_count), 32'd1);
    step(0, 9, 0, "idle");
    step(1, 3, 0, "to5");
    step(1, 5, 0, "to7");
    step(1, 11, 0, "viol");
    chk("viol.err", 32'(err), 32'd1);
    step(1, 11, 0, "reseed11");
    chk("err.one_cycle", 32'(err), 32'd0);
    step(1, 13, 0, "relock13");
    chk("relock13.expected1", 32'(expected), 32'd1);
    async_reset("rst_a");
    step(1, 4, 0, "hunt4");
    step(1, 6, 0, "hunt6");
    step(1, 0, 0, "hunt0");
    step(1, 3, 0, "conf3");
    step(1, 9, 0, "conf_bad9");
    for (int i = 0; i < 260; i++) begin
      step(1, 1, 0, "sat.a");
      step(1, 2, 0, "sat.b");
      step(1, 5, 0, "sat.v");
    end
    chk("sat.255", 32'(err_count), 32'd255);
    step(1, 1, 0, "clrv.a");
    step(1, 2, 0, "clrv.b");
    step(1, 5, 1, "clrv.v");
    chk("clrv.err", 32'(err), 32'd1);
    chk("clrv.count0", 32'(err_count), 32'd0);
    for (int l = 0; l < 3; l++) foreach (seq_v[i]) step(1, seq_v[i], 0, "laps");
    step(1, 1, 0, "laps.end");
    step(1, 2, 0, "laps.viol_armed");
    step(1, 9, 0, "laps.viol");
    async_reset("rst_err");
    step(1, 1, 0, "fresh1");
    chk("fresh1.unlocked", 32'(locked), 32'd0);
    step(1, 2, 0, "fresh2");
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom % 4) != 0;
      q = (($urandom % 4) != 0 && m_exp != 0) ? m_exp : int'($urandom % 16);
      c = ($urandom % 50) == 0;
      step(e[0], q, c[0], "rnd");
      if ($urandom % 300 == 0) async_reset("rnd_rst");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter: CNT_W, 8, width of err_count and lap_count.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 clear_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  sample strobe; q_in is consumed only on a rising edge with en=1.
REQ-005 q_in  input  4  counter value under check; legal sequence 1,2,3,5,7,11,13, then back to 1.
REQ-006 cnt_clr  input  1  synchronous clear of err_count and lap_count.
REQ-007 locked  output  1  registered; high while the FSM is in LOCKED.
REQ-008 err  output  1  registered one-cycle pulse on a sequence violation while locked.
REQ-009 expected  output  4  registered; next value predicted for q_in (0 when unpredicted).
REQ-010 err_count  output  CNT_W  saturating violation count.
REQ-011 lap_count  output  CNT_W  wrapping count of completed 13->1 laps while locked.

Function
REQ-012 The successor function succ() SHALL map 1->2, 2->3, 3->5, 5->7, 7->11, 11->13 and 13->1.
REQ-013 legal(v) SHALL be true only for v in {1,2,3,5,7,11,13}; the values 0,4,6,8,9,10,12,14,15 are illegal.
REQ-014 The FSM states SHALL be HUNT, CONFIRM and LOCKED, encoded in 2 bits; the unused encoding SHALL return to HUNT on the next edge.
REQ-015 With en=0, the state, expected, locked and both counts SHALL hold, and err SHALL be 0.
REQ-016 HUNT, en=1, legal(q_in): expected<=succ(q_in), go to CONFIRM.
REQ-017 HUNT, en=1, illegal q_in: stay in HUNT with expected=0.
REQ-018 CONFIRM, en=1, q_in==expected: expected<=succ(q_in), go to LOCKED.
REQ-019 CONFIRM, en=1, mismatch and legal(q_in): stay in CONFIRM (re-seed) with expected<=succ(q_in); no err.
REQ-020 CONFIRM, en=1, illegal q_in: go to HUNT with expected<=0; no err.
REQ-021 LOCKED, en=1, q_in==expected: expected<=succ(q_in); if q_in==1, lap_count increments, wrapping from 2^CNT_W-1 to 0.
REQ-022 LOCKED, en=1, q_in!=expected: err=1 for exactly the following cycle, err_count increments saturating at 2^CNT_W-1, go to HUNT with expected<=0.
REQ-023 Latency: locked, err, expected and the counts SHALL reflect a sample on the same edge that captures it; there is no combinational path from input to output.
REQ-024 Minimum lock latency: 2 consecutive correct samples; locked SHALL rise after the 2nd sample edge.
REQ-025 cnt_clr=1 SHALL zero both counts on the edge and take priority over a simultaneous increment; the FSM and expected SHALL be unaffected.
REQ-026 A violation SHALL NOT reuse the offending sample to re-seed; the next en sample starts the HUNT.

Reset
REQ-027 clear_n=0 SHALL immediately, independent of clk, force state=HUNT, expected=0, locked=0, err=0, err_count=0 and lap_count=0.
REQ-028 clear_n asserted mid-sequence, including during an err pulse, SHALL abort it; after deassertion, checking SHALL restart from HUNT with no residual pulse.
REQ-029 clear_n deassertion SHALL be treated as synchronous to clk by the integrator; the first edge after release SHALL be a normal sample.

Verification
REQ-030 Reset, then en=1 with q_in=1,2,3 -> locked=0 after 1, locked=1 after 2, expected=5 after 3, err=0 throughout.
REQ-031 Locked stream 1,2,3,5,7,11,13,1,2 -> lap_count=1 after the second 1, err never asserted.
REQ-032 Locked with expected=7, q_in=11 -> err=1 for one cycle, err_count=1, locked=0, expected=0; following 11,13 -> CONFIRM then LOCKED, with expected=1 after 13.
REQ-033 In HUNT, q_in=4,6,0 -> state stays HUNT, expected=0; in CONFIRM with expected=5, q_in=9 -> HUNT with no err.
REQ-034 err_count forced to 255 by repeated violations (CNT_W=8) -> stays at 255; cnt_clr asserted on the same edge as a violation -> err_count=0 and err=1.
REQ-035 clear_n pulsed low between clock edges while locked with lap_count=3 -> all outputs 0 immediately, and relock requires 2 fresh correct samples.
